// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encoding and the bit order
// used when the status flags are packed into one vector.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_ACC = 3'b111;

  localparam int unsigned FLAG_COUT = 0;
  localparam int unsigned FLAG_ZERO = 1;
  localparam int unsigned FLAG_NEG  = 2;
  localparam int unsigned FLAG_OVF  = 3;
  localparam int unsigned NUM_FLAGS = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: one adder shared by ADD/SUB/ACC, bitwise ops and
// logical shifts. Produces the WIDTH-bit result plus carry and signed overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_c;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   shl_t;
  logic [WIDTH:0]   shr_t;

  always_comb begin
    add_x = (op == OP_ACC) ? acc : a;
    add_y = (op == OP_SUB) ? ~b : ((op == OP_ACC) ? a : b);
    add_c = (op == OP_SUB) ? 1'b1 : ((op == OP_ADD) ? cin : 1'b0);
    sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_c};

    // Extra guard bit on each side catches the last bit shifted out.
    sh    = b[SHW-1:0];
    shl_t = {1'b0, a} << sh;
    shr_t = {a, 1'b0} >> sh;

    r    = '0;
    cout = 1'b0;
    ovf  = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ACC: begin
        r    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
        ovf  = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SHL: begin
        r    = shl_t[WIDTH-1:0];
        cout = shl_t[WIDTH];
      end
      default: begin
        r    = shr_t[WIDTH:1];
        cout = shr_t[0];
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides. S1 holds operands,
// S2 holds result and flags; the accumulator updates as an ACC beat leaves S1.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic [WIDTH-1:0] acc
);

  logic                 s1_valid_q;
  logic [WIDTH-1:0]     s1_a_q;
  logic [WIDTH-1:0]     s1_b_q;
  logic [2:0]           s1_op_q;
  logic                 s1_cin_q;
  logic                 s2_valid_q;
  logic [WIDTH-1:0]     result_q;
  logic [NUM_FLAGS-1:0] flags_q;
  logic [WIDTH-1:0]     acc_q;

  logic                 s1_adv;
  logic [WIDTH-1:0]     core_acc;
  logic [WIDTH-1:0]     core_r;
  logic                 core_cout;
  logic                 core_ovf;
  logic [NUM_FLAGS-1:0] core_flags;

  assign s1_adv   = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s1_adv;
  // A clear in the same cycle as an advancing ACC takes effect before the add.
  assign core_acc = acc_clr ? '0 : acc_q;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a    (s1_a_q),
    .b    (s1_b_q),
    .op   (s1_op_q),
    .cin  (s1_cin_q),
    .acc  (core_acc),
    .r    (core_r),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  always_comb begin
    core_flags            = '0;
    core_flags[FLAG_COUT] = core_cout;
    core_flags[FLAG_ZERO] = (core_r == '0);
    core_flags[FLAG_NEG]  = core_r[WIDTH-1];
    core_flags[FLAG_OVF]  = core_ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_cin_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
      acc_q      <= '0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (in_valid && in_ready) begin
        s1_a_q   <= a;
        s1_b_q   <= b;
        s1_op_q  <= op;
        s1_cin_q <= cin;
      end
      if (s1_adv) begin
        s2_valid_q <= 1'b1;
        result_q   <= core_r;
        flags_q    <= core_flags;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end
      if (s1_adv && (s1_op_q == OP_ACC)) begin
        acc_q <= core_r;
      end else if (acc_clr) begin
        acc_q <= '0;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign cout      = flags_q[FLAG_COUT];
  assign zero      = flags_q[FLAG_ZERO];
  assign neg       = flags_q[FLAG_NEG];
  assign ovf       = flags_q[FLAG_OVF];
  assign acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8): directed cases plus random traffic, checked
// against an integer-arithmetic reference model through an in-order queue.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       cin;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       cout;
  logic       zero;
  logic       neg;
  logic       ovf;
  logic [7:0] acc;

  alu_pipe #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  r;
    logic        cout;
    logic        zero;
    logic        neg;
    logic        ovf;
    logic [31:0] cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   m_acc = 0;
  bit   chk_lat = 1'b1;

  task automatic check(input string tag, input int got, input int want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int sg(int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Returns {ovf, cout, r[7:0]} from plain integer arithmetic.
  function automatic logic [9:0] model(int av, int bv, int opv, int cinv, int accv);
    int s, ss, r, c, o, sh;
    s = 0; ss = 0; r = 0; c = 0; o = 0;
    sh = bv % 8;
    case (opv)
      0: begin s = av + bv + cinv; ss = sg(av) + sg(bv) + cinv; c = (s >= 256); end
      1: begin s = av - bv; ss = sg(av) - sg(bv); c = (av >= bv); end
      7: begin s = accv + av; ss = sg(accv) + sg(av); c = (s >= 256); end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: begin r = (av << sh) % 256; c = (sh == 0) ? 0 : (av >> (8 - sh)) & 1; end
      default: begin r = av >> sh; c = (sh == 0) ? 0 : (av >> (sh - 1)) & 1; end
    endcase
    if (opv == 0 || opv == 1 || opv == 7) begin
      r = ((s % 256) + 256) % 256;
      o = (ss > 127 || ss < -128);
    end
    return {o[0], c[0], r[7:0]};
  endfunction

  // One cycle: check any output handshake, record any input handshake, advance.
  task automatic tick(output bit took);
    exp_t       e;
    logic [9:0] m;
    #1;
    took = 1'b0;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        e = q.pop_front();
        check("result", int'(result), int'(e.r));
        check("cout", int'(cout), int'(e.cout));
        check("zero", int'(zero), int'(e.zero));
        check("neg", int'(neg), int'(e.neg));
        check("ovf", int'(ovf), int'(e.ovf));
        if (chk_lat) check("latency", cyc - int'(e.cyc), 2);
      end
    end
    if (in_valid && in_ready) begin
      took = 1'b1;
      m = model(int'(a), int'(b), int'(op), int'(cin), m_acc);
      if (op == 3'd7) m_acc = int'(m[7:0]);
      e.r = m[7:0];
      e.cout = m[8];
      e.ovf = m[9];
      e.zero = (m[7:0] == 8'd0);
      e.neg = m[7];
      e.cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input int av, input int bv, input int opv, input int cinv);
    bit took;
    in_valid = 1'b1;
    a = av[7:0];
    b = bv[7:0];
    op = opv[2:0];
    cin = cinv[0];
    tick(took);
    check("accepted", int'(took), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit took;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick(took);
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    bit took;
    int sent;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0;
    acc_clr = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_result", int'(result), 0);
    check("rst_flags", int'({cout, zero, neg, ovf}), 0);
    check("rst_acc", int'(acc), 0);
    rst = 1'b0;
    @(negedge clk);

    // Arithmetic, logic and shift cases
    send(10, 5, 0, 0);    send(10, 5, 0, 1);
    send(10, 5, 1, 0);    send(5, 10, 1, 1);  send(7, 7, 1, 0);
    send(200, 100, 0, 0); send(127, 1, 0, 0); send(128, 255, 1, 0);
    send(10, 5, 2, 0);    send(10, 5, 3, 0);  send(10, 5, 4, 0);
    send(8'h81, 1, 5, 0); send(8'h81, 1, 6, 0);
    send(8'h81, 0, 5, 0); send(8'h81, 8'h09, 5, 0); send(8'h81, 7, 6, 0);
    drain();

    // Accumulator
    send(50, 0, 7, 0);
    drain();
    check("acc_50", int'(acc), 50);
    acc_clr = 1'b1; tick(took); acc_clr = 1'b0; m_acc = 0;
    check("acc_cleared", int'(acc), 0);
    send(3, 99, 7, 1); send(4, 0, 7, 0); send(5, 0, 7, 0);
    drain();
    check("acc_12", int'(acc), 12);
    acc_clr = 1'b1; m_acc = 0;
    send(9, 0, 7, 0);
    tick(took);
    acc_clr = 1'b0;
    drain();
    check("acc_9", int'(acc), 9);

    // Output stall with 4 streamed beats
    chk_lat = 1'b0;
    sent = 0;
    a = 8'd11; b = 8'd1; op = 3'd0; cin = 1'b0;
    for (int t = 0; t < 30 && sent < 4; t++) begin
      out_ready = (t >= 4);
      in_valid = 1'b1;
      if (t == 3) begin
        #1;
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_held", q.size(), 2);
      end
      tick(took);
      if (took) begin
        sent++;
        a = a + 8'd10;
      end
    end
    check("stall_sent", sent, 4);
    drain();

    // Reset in the middle of a stream
    out_ready = 1'b1;
    send(20, 0, 7, 0); send(30, 0, 7, 0); send(1, 2, 0, 0);
    check("pre_rst_valid", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_acc", int'(acc), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    q.delete();
    m_acc = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      a   = 8'($urandom);
      b   = 8'($urandom);
      op  = 3'($urandom);
      cin = 1'($urandom);
      tick(took);
    end
    drain();
    check("rand_acc", int'(acc), m_acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
